// File: rtl/bram_client_pkg.sv
// Shared helpers for the single-port BRAM client: counter and pointer sizing.
package bram_client_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Wide enough to hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_client_rsp_fifo.sv
// In-order DEPTH-entry synchronous response FIFO with occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module bram_client_rsp_fifo
  import bram_client_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Upstream credit accounting must make a push into a full FIFO impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/bram_1rw_client.sv
// Valid/ready request adapter for a single-port BRAM with in-order response FIFO.
// Define BRAM_CLIENT_WRACK_EN to make writes return an in-order ack (rdata=0).
module bram_1rw_client
  import bram_client_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  input  logic [DATA_WIDTH-1:0] bram_douta
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  is_ack;
  } rsp_entry_t;

  localparam int unsigned CW = cnt_width(RSP_DEPTH);
  localparam int unsigned UW = cnt_width(RSP_DEPTH + 1);

  logic [CW-1:0] occupancy;
  logic [UW-1:0] used;
  logic          pop;
  logic          fire;
  logic          infl_valid;
  logic          infl_is_wr;
  rsp_entry_t    push_entry;
  rsp_entry_t    head_entry;

`ifdef BRAM_CLIENT_WRACK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      infl_valid <= 1'b0;
      infl_is_wr <= 1'b0;
    end else begin
      infl_valid <= fire;
      infl_is_wr <= fire && req_write;
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) infl_valid <= 1'b0;
    else        infl_valid <= fire && !req_write;
  end

  assign infl_is_wr = 1'b0;
`endif

  always_comb begin
    pop       = rsp_valid && rsp_ready;
    // A slot freed by this cycle's pop can be re-granted immediately.
    used      = UW'(occupancy) + UW'(infl_valid) - UW'(pop);
    req_ready = RST_N && (used < UW'(RSP_DEPTH));
    fire      = req_valid && req_ready;

    bram_ena   = fire;
    bram_wea   = fire && req_write;
    bram_addra = req_addr;
    bram_dina  = req_wdata;

    push_entry.rdata  = infl_is_wr ? '0 : bram_douta;
    push_entry.is_ack = infl_is_wr;

    rsp_valid = (occupancy != '0);
    rsp_rdata = (rsp_valid && !head_entry.is_ack) ? head_entry.rdata : '0;
  end

  bram_client_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (infl_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_bram_1rw_client.sv
// Directed self-checking bench for bram_1rw_client with a behavioural BRAM.
module tb_bram_1rw_client;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        bram_ena;
  logic        bram_wea;
  logic [9:0]  bram_addra;
  logic [31:0] bram_dina;
  logic [31:0] bram_douta;

  logic [31:0] bram_mem [1024];

  int n_checks;
  int n_fail;

  bram_1rw_client #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .RSP_DEPTH  (2)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_douta (bram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output register only loads on a read enable, so it holds across writes.
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wea) bram_mem[bram_addra] <= bram_dina;
      else          bram_douta <= bram_mem[bram_addra];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [9:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    bram_douta = '0;
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    drive(1'b1, 1'b1, 10'd0, 32'h0);
    #2;
    chk("rst_ena", {31'd0, bram_ena}, 32'd0);
    chk("rst_wea", {31'd0, bram_wea}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    cycle();
    chk("rst_rsp_valid_edge", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    rsp_ready = 1'b1;
    cycle();

`ifndef BRAM_CLIENT_WRACK_EN
    // Write 0xDEADBEEF to 5, then read it back.
    drive(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    #1;
    chk("wr_ready", {31'd0, req_ready}, 32'd1);
    chk("wr_ena", {31'd0, bram_ena}, 32'd1);
    chk("wr_wea", {31'd0, bram_wea}, 32'd1);
    chk("wr_addra", {22'd0, bram_addra}, 32'd5);
    chk("wr_dina", bram_dina, 32'hDEADBEEF);
    cycle();
    drive(1'b1, 1'b0, 10'd5, 32'h0);
    #1;
    chk("rd_wea", {31'd0, bram_wea}, 32'd0);
    chk("rd_ena", {31'd0, bram_ena}, 32'd1);
    chk("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("rd_not_yet", {31'd0, rsp_valid}, 32'd0);
    cycle();
    chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_data", rsp_rdata, 32'hDEADBEEF);
    cycle();
    chk("rd_drained", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back reads of 0..7 holding addr*3.
    for (int i = 0; i < 8; i++) bram_mem[i] = 32'(i * 3);
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 10'(k), 32'h0);
      else       drive(1'b0, 1'b0, 10'd0, 32'h0);
      #1;
      if (k < 8) chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      if (k >= 2) begin
        chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_data", rsp_rdata, 32'((k - 2) * 3));
      end
      cycle();
    end
    chk("b2b_drained", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: two reads fill the credits, release drains in order.
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd0, 32'h0);
    #1;
    chk("bp_ready0", {31'd0, req_ready}, 32'd1);
    cycle();
    drive(1'b1, 1'b0, 10'd1, 32'h0);
    #1;
    chk("bp_ready1", {31'd0, req_ready}, 32'd1);
    cycle();
    drive(1'b1, 1'b0, 10'd2, 32'h0);
    #1;
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_ena_low", {31'd0, bram_ena}, 32'd0);
    chk("bp_head0", rsp_rdata, 32'd0);
    cycle();
    chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_full_head", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_head", rsp_rdata, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("bp_second", rsp_rdata, 32'd3);
    chk("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    cycle();
    chk("bp_third", rsp_rdata, 32'd6);
    cycle();
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Read then write same address: the read must see the old value.
    bram_mem[2] = 32'hAA;
    drive(1'b1, 1'b0, 10'd2, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 10'd2, 32'h1);
    #1;
    chk("rw_wea", {31'd0, bram_wea}, 32'd1);
    cycle();
    drive(1'b1, 1'b0, 10'd2, 32'h0);
    #1;
    chk("rw_old_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rw_old_data", rsp_rdata, 32'hAA);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("rw_gap", {31'd0, rsp_valid}, 32'd0);
    cycle();
    chk("rw_new_data", rsp_rdata, 32'h1);
    cycle();
`endif

    // Reset while a read is inflight discards it.
    bram_mem[3] = 32'h9;
    drive(1'b1, 1'b0, 10'd3, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 10'd4, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ena", {31'd0, bram_ena}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_valid0", {31'd0, rsp_valid}, 32'd0);
    cycle();
    chk("post_rst_valid1", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_rdata", rsp_rdata, 32'd0);

`ifdef BRAM_CLIENT_WRACK_EN
    // write, read, write -> ack, data, ack in order.
    drive(1'b1, 1'b1, 10'd10, 32'h55);
    #1;
    chk("ack_w0_ready", {31'd0, req_ready}, 32'd1);
    cycle();
    drive(1'b1, 1'b0, 10'd10, 32'h0);
    #1;
    chk("ack_r_ready", {31'd0, req_ready}, 32'd1);
    cycle();
    drive(1'b1, 1'b1, 10'd11, 32'h66);
    #1;
    chk("ack_w1_ready", {31'd0, req_ready}, 32'd1);
    chk("ack0_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ack0_data", rsp_rdata, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("ack_data_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ack_data", rsp_rdata, 32'h55);
    cycle();
    chk("ack1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ack1_data", rsp_rdata, 32'd0);
    cycle();
    chk("ack_drained", {31'd0, rsp_valid}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
